// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding and the address-error check.
package data_memory_responder_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  // Misaligned, or any bit above the stored word range set.
  function automatic logic addr_error(
    input logic [31:0] a,
    input int          dl2
  );
    logic err;
    err = (a[1:0] != 2'b00);
    for (int i = 0; i < 32; i++) begin
      if (i >= dl2 + 2 && a[i]) err = 1'b1;
    end
    return err;
  endfunction

endpackage

// File: rtl/data_memory_array.sv
// Word-addressed storage: synchronous write, asynchronous read,
// asynchronous active-low clear zeroes every word.
module data_memory_array
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [WORD_WIDTH-1:0] i_wdata,
  output logic [WORD_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_memory_responder.sv
// Handshaked data-memory responder: one request in flight,
// fixed latency, error flag for misaligned/out-of-range.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_read_data,
  output logic        resp_error
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_write;
  logic [31:0]           r_addr;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic                  r_resp_valid;
  logic [WORD_WIDTH-1:0] r_resp_data;
  logic                  r_resp_error;

  logic                  w_accept;
  logic                  w_error;
  logic                  w_fire;
  logic                  w_we;
  logic [DEPTH_LOG2-1:0] w_index;
  logic [WORD_WIDTH-1:0] w_rdata;

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_index   = r_addr[DEPTH_LOG2+1:2];
  assign w_error   = addr_error(r_addr, DEPTH_LOG2);
  // First RESPOND cycle performs the access and raises resp_valid.
  assign w_fire    = (r_state == ST_RESPOND) && !r_resp_valid;
  assign w_we      = w_fire && r_write && !w_error;

  data_memory_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clock  (clock),
    .clear  (clear),
    .i_we   (w_we),
    .i_addr (w_index),
    .i_wdata(r_wdata),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_address;
            r_wdata <= req_write_data;
            if (WAIT_CYCLES > 0) begin
              r_cnt   <= WAIT_INIT;
              r_state <= ST_WAIT;
            end else begin
              r_state <= ST_RESPOND;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (w_fire) begin
            r_resp_valid <= 1'b1;
            r_resp_error <= w_error;
            r_resp_data  <= (w_error || r_write) ? '0 : w_rdata;
          end else if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_error <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid     = r_resp_valid;
  assign resp_read_data = r_resp_data;
  assign resp_error     = r_resp_error;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: unit 1 uses WAIT_CYCLES=2, unit 0 WAIT_CYCLES=0.
// Vector table plus hand sequences for stall, ignore and reset.
module tb_data_memory_responder;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        req_valid      [2];
  logic        req_ready      [2];
  logic        req_write      [2];
  logic [31:0] req_address    [2];
  logic [31:0] req_write_data [2];
  logic        resp_valid     [2];
  logic        resp_ready     [2];
  logic [31:0] resp_read_data [2];
  logic        resp_error     [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  data_memory_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_w0 (
    .clock         (clock),
    .clear         (clear),
    .req_valid     (req_valid[0]),
    .req_ready     (req_ready[0]),
    .req_write     (req_write[0]),
    .req_address   (req_address[0]),
    .req_write_data(req_write_data[0]),
    .resp_valid    (resp_valid[0]),
    .resp_ready    (resp_ready[0]),
    .resp_read_data(resp_read_data[0]),
    .resp_error    (resp_error[0])
  );

  data_memory_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_w2 (
    .clock         (clock),
    .clear         (clear),
    .req_valid     (req_valid[1]),
    .req_ready     (req_ready[1]),
    .req_write     (req_write[1]),
    .req_address   (req_address[1]),
    .req_write_data(req_write_data[1]),
    .resp_valid    (resp_valid[1]),
    .resp_ready    (resp_ready[1]),
    .resp_read_data(resp_read_data[1]),
    .resp_error    (resp_error[1])
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input int u, input logic w, input logic [31:0] a,
                       input logic [31:0] d, output int lat);
    @(negedge clock);
    chk($sformatf("u%0d_accept_rdy", u), 32'(req_ready[u]), 32'd1);
    req_valid[u]      = 1'b1;
    req_write[u]      = w;
    req_address[u]    = a;
    req_write_data[u] = d;
    resp_ready[u]     = 1'b0;
    @(posedge clock);
    #1;
    req_valid[u] = 1'b0;
    lat = 0;
    while (!resp_valid[u] && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic consume(input int u, input string name);
    @(negedge clock);
    resp_ready[u] = 1'b1;
    @(posedge clock);
    #1;
    resp_ready[u] = 1'b0;
    chk({name, "_valid_drop"}, 32'(resp_valid[u]), 32'd0);
    chk({name, "_rdy_back"}, 32'(req_ready[u]), 32'd1);
  endtask

  task automatic txn(input int u, input vec_t v, input int exp_lat,
                     input string name);
    int lat;
    issue(u, v.w, v.a, v.d, lat);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_data"}, resp_read_data[u], v.exp_d);
    chk({name, "_err"}, 32'(resp_error[u]), 32'(v.exp_e));
    consume(u, name);
  endtask

  task automatic chk_idle(input int u, input string name);
    chk({name, "_rdy"}, 32'(req_ready[u]), 32'd1);
    chk({name, "_valid"}, 32'(resp_valid[u]), 32'd0);
    chk({name, "_data"}, resp_read_data[u], 32'd0);
    chk({name, "_err"}, 32'(resp_error[u]), 32'd0);
  endtask

  initial begin
    int lat;
    tbl[0] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b0};
    tbl[1] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         1'b0};
    tbl[2] = '{1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[3] = '{1'b1, 32'h0000_0042, 32'h1234_5678, 32'h0,         1'b1};
    tbl[4] = '{1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0,         1'b1};
    tbl[5] = '{1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[6] = '{1'b1, 32'h0000_03FC, 32'h1122_3344, 32'h0,         1'b0};
    tbl[7] = '{1'b0, 32'h0000_03FC, 32'h0,         32'h1122_3344, 1'b0};
    tbl[8] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b1};
    tbl[9] = '{1'b0, 32'h0000_0041, 32'h0,         32'h0,         1'b1};

    for (int u = 0; u < 2; u++) begin
      req_valid[u]      = 1'b0;
      req_write[u]      = 1'b0;
      req_address[u]    = '0;
      req_write_data[u] = '0;
      resp_ready[u]     = 1'b0;
    end

    // Reset: ready is already high while clear is low.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hold_rdy", 32'(req_ready[1]), 32'd1);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    chk_idle(1, "rst_w2");
    chk_idle(0, "rst_w0");

    for (int i = 0; i < 10; i++) begin
      txn(1, tbl[i], 3, $sformatf("vec%0d", i));
    end

    // Held response under backpressure.
    issue(1, 1'b0, 32'h0000_0040, 32'h0, lat);
    chk("bp_lat", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("bp%0d_valid", k), 32'(resp_valid[1]), 32'd1);
      chk($sformatf("bp%0d_data", k), resp_read_data[1], 32'hDEAD_BEEF);
      chk($sformatf("bp%0d_rdy", k), 32'(req_ready[1]), 32'd0);
    end
    consume(1, "bp");

    // Zero-wait build, plus a request pulse that must be ignored.
    txn(0, '{1'b1, 32'h8, 32'h5555_AAAA, 32'h0, 1'b0}, 1, "w0_st");
    issue(0, 1'b0, 32'h8, 32'h0, lat);
    chk("w0_ld_lat", 32'(lat), 32'd1);
    chk("w0_ld_data", resp_read_data[0], 32'h5555_AAAA);
    @(negedge clock);
    req_valid[0]      = 1'b1;
    req_write[0]      = 1'b1;
    req_address[0]    = 32'h8;
    req_write_data[0] = 32'hFFFF_FFFF;
    @(posedge clock);
    #1;
    req_valid[0] = 1'b0;
    chk("w0_ign_valid", 32'(resp_valid[0]), 32'd1);
    chk("w0_ign_data", resp_read_data[0], 32'h5555_AAAA);
    consume(0, "w0_ign");
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("w0_noextra%0d", k), 32'(resp_valid[0]), 32'd0);
    end
    txn(0, '{1'b0, 32'h8, 32'h0, 32'h5555_AAAA, 1'b0}, 1, "w0_reld");

    // Reset during WAIT drops the pending store.
    @(negedge clock);
    req_valid[1]      = 1'b1;
    req_write[1]      = 1'b1;
    req_address[1]    = 32'h0000_0080;
    req_write_data[1] = 32'hA5A5_A5A5;
    @(posedge clock);
    #1;
    req_valid[1] = 1'b0;
    chk("mid_wait_rdy", 32'(req_ready[1]), 32'd0);
    #2;
    clear = 1'b0;
    #1;
    chk_idle(1, "mid_rst");
    @(negedge clock);
    @(negedge clock);
    clear = 1'b1;
    txn(1, '{1'b0, 32'h80, 32'h0, 32'h0, 1'b0}, 3, "mid_ld80");
    txn(1, '{1'b0, 32'h40, 32'h0, 32'h0, 1'b0}, 3, "mid_ld40");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
